// File: rtl/spi_link_host.sv
// Host-side initiator for the chip serial register link: iclk pointer-reset burst,
// then an address byte and cmd_len full-duplex data bytes, LSB first, on sclk/sdo/sdi.
module spi_link_host #(
   parameter int unsigned CLK_DIV     = 1,
   parameter int unsigned IRST_PULSES = 8
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       cmd_valid,
   output logic       cmd_ready,
   input  logic [7:0] cmd_addr,
   input  logic [7:0] cmd_len,
   input  logic [7:0] tx_data,
   input  logic       tx_valid,
   output logic       tx_ready,
   output logic [7:0] rx_data,
   output logic       rx_valid,
   output logic       busy,
   output logic       done,
   output logic       sclk,
   output logic       iclk,
   output logic       sdo,
   input  logic       sdi
);

   localparam int unsigned DIV_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
   localparam int unsigned PLS_W = (IRST_PULSES > 1) ? $clog2(IRST_PULSES) : 1;
   localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);
   localparam logic [PLS_W-1:0] PLS_LAST = PLS_W'(IRST_PULSES - 1);

   typedef enum logic [2:0] {
      IDLE, IRST_HI, IRST_LO, LOAD, BIT_LO, BIT_HI, FIN
   } state_t;

   state_t           state;
   logic [DIV_W-1:0] div_cnt;
   logic [PLS_W-1:0] pulse_cnt;
   logic [2:0]       bit_cnt;
   logic [8:0]       bytes_left;
   logic             first_byte;
   logic [7:0]       addr_q;
   logic [7:0]       shift;
   logic [7:0]       rx_shift;

   // Pin outputs are set on the transition into each state, so their level
   // always matches the state currently being held.
   always_ff @(posedge clk) begin
      if (rst) begin
         state      <= IDLE;
         div_cnt    <= '0;
         pulse_cnt  <= '0;
         bit_cnt    <= '0;
         bytes_left <= '0;
         first_byte <= 1'b0;
         addr_q     <= '0;
         shift      <= '0;
         rx_shift   <= '0;
         cmd_ready  <= 1'b1;
         tx_ready   <= 1'b0;
         rx_data    <= '0;
         rx_valid   <= 1'b0;
         busy       <= 1'b0;
         done       <= 1'b0;
         sclk       <= 1'b0;
         iclk       <= 1'b0;
         sdo        <= 1'b0;
      end else begin
         rx_valid <= 1'b0;
         done     <= 1'b0;
         case (state)
            IDLE: begin
               if (cmd_valid) begin
                  addr_q     <= cmd_addr;
                  bytes_left <= {1'b0, cmd_len} + 9'd1;
                  first_byte <= 1'b1;
                  div_cnt    <= '0;
                  pulse_cnt  <= '0;
                  cmd_ready  <= 1'b0;
                  busy       <= 1'b1;
                  iclk       <= 1'b1;
                  sdo        <= 1'b0;
                  state      <= IRST_HI;
               end
            end
            IRST_HI: begin
               if (div_cnt == DIV_LAST) begin
                  div_cnt <= '0;
                  iclk    <= 1'b0;
                  state   <= IRST_LO;
               end else begin
                  div_cnt <= div_cnt + DIV_W'(1);
               end
            end
            IRST_LO: begin
               if (div_cnt == DIV_LAST) begin
                  div_cnt <= '0;
                  if (pulse_cnt == PLS_LAST) begin
                     state <= LOAD;
                  end else begin
                     pulse_cnt <= pulse_cnt + PLS_W'(1);
                     iclk      <= 1'b1;
                     state     <= IRST_HI;
                  end
               end else begin
                  div_cnt <= div_cnt + DIV_W'(1);
               end
            end
            LOAD: begin
               bit_cnt <= '0;
               div_cnt <= '0;
               if (first_byte) begin
                  shift <= addr_q;
                  sdo   <= addr_q[0];
                  state <= BIT_LO;
               end else if (tx_valid) begin
                  shift    <= tx_data;
                  sdo      <= tx_data[0];
                  tx_ready <= 1'b0;
                  state    <= BIT_LO;
               end
            end
            BIT_LO: begin
               if (div_cnt == DIV_LAST) begin
                  div_cnt <= '0;
                  sclk    <= 1'b1;
                  state   <= BIT_HI;
               end else begin
                  div_cnt <= div_cnt + DIV_W'(1);
               end
            end
            BIT_HI: begin
               if (div_cnt == DIV_LAST) begin
                  div_cnt  <= '0;
                  sclk     <= 1'b0;
                  rx_shift <= {sdi, rx_shift[7:1]};
                  if (bit_cnt == 3'd7) begin
                     first_byte <= 1'b0;
                     bytes_left <= bytes_left - 9'd1;
                     // The address byte's capture is discarded.
                     if (!first_byte) begin
                        rx_valid <= 1'b1;
                        rx_data  <= {sdi, rx_shift[7:1]};
                     end
                     if (bytes_left == 9'd1) begin
                        busy  <= 1'b0;
                        done  <= 1'b1;
                        sdo   <= 1'b0;
                        state <= FIN;
                     end else begin
                        tx_ready <= 1'b1;
                        state    <= LOAD;
                     end
                  end else begin
                     bit_cnt <= bit_cnt + 3'd1;
                     shift   <= {1'b0, shift[7:1]};
                     sdo     <= shift[1];
                     state   <= BIT_LO;
                  end
               end else begin
                  div_cnt <= div_cnt + DIV_W'(1);
               end
            end
            FIN: begin
               cmd_ready <= 1'b1;
               state     <= IDLE;
            end
            default: begin
               cmd_ready <= 1'b1;
               busy      <= 1'b0;
               tx_ready  <= 1'b0;
               sclk      <= 1'b0;
               iclk      <= 1'b0;
               sdo       <= 1'b0;
               state     <= IDLE;
            end
         endcase
      end
   end

endmodule
